// File: rtl/rast_sample_iter_pkg.sv
// Shared constants and types for the rasterizer sample iterator: coordinate
// formats, triangle/color containers, lane vectors and the iterator state.
package rast_sample_iter_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int LANES  = 2;
    localparam int SS_MAX = 3;
    localparam int SS_W   = $clog2(SS_MAX + 1);

    typedef logic signed [SIGFIG-1:0] coord_t;
    // One extra bit so that box walking near the positive limit never wraps.
    typedef logic signed [SIGFIG:0]   wide_t;

    typedef coord_t [AXIS-1:0]    vert_t;
    typedef vert_t  [VERTS-1:0]   tri_t;
    typedef coord_t [COLORS-1:0]  color_t;
    typedef coord_t [LANES-1:0]   lane_x_t;
    typedef logic   [LANES-1:0]   lane_mask_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } point2_t;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } iter_state_e;

    // Sample pitch for a requested subsample shift, clamped to SS_MAX.
    function automatic wide_t step_for(logic [SS_W-1:0] ss);
        logic [SS_W:0] ss_ext;
        ss_ext = {1'b0, ss};
        if (ss_ext > (SS_W+1)'(SS_MAX)) begin
            ss_ext = (SS_W+1)'(SS_MAX);
        end
        return wide_t'(1) << (RADIX - int'(ss_ext));
    endfunction

endpackage

// File: rtl/rast_sample_iter_if.sv
// Triangle-in / sample-beat-out bundle of the sample iterator. The iterator
// itself uses the slave view; the feeding and consuming logic uses master.
interface rast_sample_iter_if;
    import rast_sample_iter_pkg::*;

    logic              in_valid;
    logic              in_ready;
    tri_t              tri_i;
    color_t            color_i;
    point2_t           box_ll_i;
    point2_t           box_ur_i;
    logic [SS_W-1:0]   ss_shift_i;

    logic              out_valid;
    logic              out_ready;
    tri_t              tri_o;
    color_t            color_o;
    coord_t            samp_y_o;
    lane_x_t           samp_x_o;
    lane_mask_t        lane_mask_o;
    logic              last_o;

    modport slave (
        input  in_valid, tri_i, color_i, box_ll_i, box_ur_i, ss_shift_i, out_ready,
        output in_ready, out_valid, tri_o, color_o, samp_y_o, samp_x_o, lane_mask_o, last_o
    );

    modport master (
        output in_valid, tri_i, color_i, box_ll_i, box_ur_i, ss_shift_i, out_ready,
        input  in_ready, out_valid, tri_o, color_o, samp_y_o, samp_x_o, lane_mask_o, last_o
    );

endinterface

// File: rtl/rast_lane_gen.sv
// Combinational lane expansion: x positions for LANES adjacent samples, their
// in-box mask, the x of the next beat and whether this beat closes the row.
module rast_lane_gen
    import rast_sample_iter_pkg::*;
(
    input  coord_t     cur_x,
    input  wide_t      step,
    input  coord_t     ur_x,
    output lane_x_t    lane_x,
    output lane_mask_t lane_mask,
    output logic       row_end,
    output coord_t     next_x
);

    wide_t cur_w;
    wide_t ur_w;
    wide_t adv_w;

    assign cur_w = wide_t'(cur_x);
    assign ur_w  = wide_t'(ur_x);
    assign adv_w = cur_w + wide_t'(LANES) * step;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            wide_t x_w;
            assign x_w           = cur_w + wide_t'(gi) * step;
            // Out-of-box lanes are truncated too; the mask tells consumers to skip them.
            assign lane_x[gi]    = x_w[SIGFIG-1:0];
            assign lane_mask[gi] = (x_w <= ur_w);
        end
    endgenerate

    assign row_end = (adv_w > ur_w);
    assign next_x  = adv_w[SIGFIG-1:0];

endmodule

// File: rtl/rast_sample_iter.sv
// Walks a triangle's snapped bounding box in raster order, emitting LANES
// samples per beat. Define RAST_SAMPLE_ITER_STATS_EN for capture/sample counters.
module rast_sample_iter
    import rast_sample_iter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rast_sample_iter_if.slave   bus
`ifdef RAST_SAMPLE_ITER_STATS_EN
    ,
    output logic [31:0]         stat_tri_o,
    output logic [31:0]         stat_samp_o
`endif
);

    iter_state_e state_reg;
    iter_state_e state_next;

    tri_t        tri_reg;
    color_t      color_reg;
    point2_t     ur_reg;
    coord_t      ll_x_reg;
    wide_t       step_reg;
    coord_t      cur_x_reg;
    coord_t      cur_y_reg;

    lane_x_t     lane_x;
    lane_mask_t  lane_mask;
    logic        row_end;
    coord_t      row_next_x;
    wide_t       next_y_w;
    logic        col_end;

    logic        box_ok;
    logic        in_ready;
    logic        out_valid;
    logic        last;
    logic        capture;
    logic        beat_fire;

    rast_lane_gen u_lane_gen (
        .cur_x     (cur_x_reg),
        .step      (step_reg),
        .ur_x      (ur_reg.x),
        .lane_x    (lane_x),
        .lane_mask (lane_mask),
        .row_end   (row_end),
        .next_x    (row_next_x)
    );

    assign next_y_w = wide_t'(cur_y_reg) + step_reg;
    assign col_end  = (next_y_w > wide_t'($signed(ur_reg.y)));

    assign box_ok = ($signed(bus.box_ll_i.x) <= $signed(bus.box_ur_i.x)) &&
                    ($signed(bus.box_ll_i.y) <= $signed(bus.box_ur_i.y));

    always_comb begin
        state_next = state_reg;
        out_valid  = 1'b0;
        last       = 1'b0;
        in_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
            end
            ITER: begin
                out_valid = 1'b1;
                last      = row_end & col_end;
                // Accepting on the closing beat lets the next triangle follow with no bubble.
                in_ready  = last & bus.out_ready;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!rst) begin
            in_ready = 1'b0;
        end
        capture   = bus.in_valid & in_ready & box_ok;
        beat_fire = out_valid & bus.out_ready;
        if (capture) begin
            state_next = ITER;
        end else if (beat_fire && last) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            tri_reg   <= '0;
            color_reg <= '0;
            ur_reg    <= '0;
            ll_x_reg  <= '0;
            step_reg  <= '0;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                tri_reg   <= bus.tri_i;
                color_reg <= bus.color_i;
                ur_reg    <= bus.box_ur_i;
                ll_x_reg  <= bus.box_ll_i.x;
                step_reg  <= step_for(bus.ss_shift_i);
                cur_x_reg <= bus.box_ll_i.x;
                cur_y_reg <= bus.box_ll_i.y;
            end else if (beat_fire && !last) begin
                if (row_end) begin
                    cur_x_reg <= ll_x_reg;
                    cur_y_reg <= next_y_w[SIGFIG-1:0];
                end else begin
                    cur_x_reg <= row_next_x;
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.last_o      = last;
    assign bus.lane_mask_o = out_valid ? lane_mask : '0;
    assign bus.samp_x_o    = lane_x;
    assign bus.samp_y_o    = cur_y_reg;
    assign bus.tri_o       = tri_reg;
    assign bus.color_o     = color_reg;

`ifdef RAST_SAMPLE_ITER_STATS_EN
    logic [31:0] stat_tri_reg;
    logic [31:0] stat_samp_reg;
    logic [32:0] samp_sum;

    assign samp_sum = {1'b0, stat_samp_reg} + 33'($countones(lane_mask));

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_tri_reg  <= '0;
            stat_samp_reg <= '0;
        end else begin
            if (capture && (stat_tri_reg != '1)) begin
                stat_tri_reg <= stat_tri_reg + 32'd1;
            end
            if (beat_fire) begin
                stat_samp_reg <= samp_sum[32] ? '1 : samp_sum[31:0];
            end
        end
    end

    assign stat_tri_o  = stat_tri_reg;
    assign stat_samp_o = stat_samp_reg;
`endif

endmodule

// File: tb/tb_rast_sample_iter.sv
// Bench for rast_sample_iter: a box-walking model fills a queue of expected
// beats that a per-cycle compare process checks the outputs against.
module tb_rast_sample_iter;
    import rast_sample_iter_pkg::*;

    typedef struct packed {
        coord_t     y;
        lane_x_t    x;
        lane_mask_t mask;
        logic       last;
        tri_t       tv;
        color_t     cv;
    } beat_t;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     ready_mode = 0;
    int     tri_idx = 0;
    longint m_tri = 0;
    longint m_samp = 0;
    beat_t  exp_q[$];

    always #5 clk = ~clk;

    rast_sample_iter_if bus();

`ifdef RAST_SAMPLE_ITER_STATS_EN
    logic [31:0] stat_tri_o;
    logic [31:0] stat_samp_o;
`endif

    rast_sample_iter dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef RAST_SAMPLE_ITER_STATS_EN
        ,
        .stat_tri_o  (stat_tri_o),
        .stat_samp_o (stat_samp_o)
`endif
    );

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Raster walk of the box straight from its definition: rows by step, beats by LANES*step.
    function automatic void gen_beats(longint llx, longint lly, longint urx, longint ury,
                                      int ss, tri_t tv, color_t cv);
        longint step;
        longint xk;
        beat_t  b;
        int     ssc;
        ssc  = (ss > SS_MAX) ? SS_MAX : ss;
        step = longint'(1) << (RADIX - ssc);
        for (longint y = lly; y <= ury; y += step) begin
            for (longint x = llx; x <= urx; x += LANES * step) begin
                b   = '0;
                b.y = coord_t'(y);
                for (int k = 0; k < LANES; k++) begin
                    xk        = x + k * step;
                    b.x[k]    = coord_t'(xk);
                    b.mask[k] = (xk <= urx);
                end
                b.last = (y + step > ury) && (x + LANES * step > urx);
                b.tv   = tv;
                b.cv   = cv;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic send(int llx, int lly, int urx, int ury, int ss);
        tri_t   tv;
        color_t cv;
        bit     acc;
        bit     ok;
        int     n;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tv[v][a] = coord_t'($urandom);
        for (int c = 0; c < COLORS; c++)
            cv[c] = coord_t'($urandom);
        bus.tri_i      = tv;
        bus.color_i    = cv;
        bus.box_ll_i.x = coord_t'(llx);
        bus.box_ll_i.y = coord_t'(lly);
        bus.box_ur_i.x = coord_t'(urx);
        bus.box_ur_i.y = coord_t'(ury);
        bus.ss_shift_i = SS_W'(ss);
        bus.in_valid   = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = bus.in_ready && rst;
            @(posedge clk);
            n++;
        end
        chk("in_ready_wait", acc, 1);
        ok = (llx <= urx) && (lly <= ury);
        if (acc && ok) begin
            m_tri++;
            gen_beats(llx, lly, urx, ury, ss, tv, cv);
        end
        $display("tri %0d: ll=(%0d,%0d) ur=(%0d,%0d) ss=%0d %s", tri_idx, lly, llx, ury, urx, ss,
                 ok ? "queued" : "dropped");
        tri_idx++;
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle comparison against the head of the expected-beat queue.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            chk("out_valid", bus.out_valid, (exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("samp_y", bus.samp_y_o, e.y);
                chk("samp_x", bus.samp_x_o, e.x);
                chk("lane_mask", bus.lane_mask_o, e.mask);
                chk("last", bus.last_o, e.last);
                chk("tri_o", bus.tri_o, e.tv);
                chk("color_o", bus.color_o, e.cv);
                chk("in_ready_iter", bus.in_ready, e.last & bus.out_ready);
                if (bus.out_ready) begin
                    m_samp += $countones(e.mask);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("in_ready_idle", bus.in_ready, 1);
                chk("mask_idle", bus.lane_mask_o, 0);
                chk("last_idle", bus.last_o, 0);
            end
        end
    end

    initial begin
        int ss;
        int step;
        int llx;
        int lly;
        int nx;
        int ny;
        int maxs;

        bus.in_valid   = 1'b0;
        bus.tri_i      = '0;
        bus.color_i    = '0;
        bus.box_ll_i   = '0;
        bus.box_ur_i   = '0;
        bus.ss_shift_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_last", bus.last_o, 0);
        chk("rst_mask", bus.lane_mask_o, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_samp_y", bus.samp_y_o, 0);
        chk("rst_samp_x", bus.samp_x_o, 0);
        chk("rst_tri", bus.tri_o, 0);
        chk("rst_color", bus.color_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 2x2 pixel box at full pitch: four beats, odd lane masked at row end.
        send(0, 0, 2048, 1024, 0);
        chk("model_beats", exp_q.size(), 4);
        chk("model_b1_x0", exp_q[1].x[0], 2048);
        chk("model_b1_mask", exp_q[1].mask, 2'b01);
        chk("model_b2_y", exp_q[2].y, 1024);
        chk("model_b3_last", exp_q[3].last, 1);
        @(negedge clk);
        chk("t1_latency_valid", bus.out_valid, 1);
        chk("t1_lane1_x", bus.samp_x_o[1], 1024);
        chk("t1_mask", bus.lane_mask_o, 2'b11);
        wait_drain("drain_t1");

        // Quarter-pixel pitch.
        send(0, 0, 256, 256, 2);
        chk("model_ss2_beats", exp_q.size(), 2);
        chk("model_ss2_x1", exp_q[0].x[1], 256);
        chk("model_ss2_y1", exp_q[1].y, 256);
        chk("model_ss2_mask", exp_q[1].mask, 2'b11);
        wait_drain("drain_ss2");

        // Backpressure held mid-row for three cycles.
        send(0, 0, 1024, 256, 2);
        @(negedge clk);
        ready_mode = 2;
        repeat (3) @(negedge clk);
        ready_mode = 0;
        wait_drain("drain_stall");

        // Degenerate box is swallowed.
        send(4096, 0, 0, 1024, 0);
        repeat (5) @(posedge clk);
        #1;

        // Back-to-back triangles.
        send(0, 0, 1024, 0, 0);
        send(-2048, -1024, -1024, -1024, 1);
        wait_drain("drain_b2b");

        // Reset while iterating.
        send(0, 0, 8192, 4096, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        m_tri  = 0;
        m_samp = 0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready2", bus.in_ready, 0);
        chk("midrst_mask", bus.lane_mask_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", bus.in_ready, 1);
        chk("postrst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;

        // Randomised boxes with random backpressure, including the positive x limit.
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            ss   = $urandom_range(0, SS_MAX);
            step = 1 << (RADIX - ss);
            maxs = (((1 << (SIGFIG - 1)) - 1) / step) * step;
            llx  = ($urandom_range(0, 40) - 20) * step;
            lly  = ($urandom_range(0, 40) - 20) * step;
            nx   = $urandom_range(0, 5);
            ny   = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) nx = -1;
            if (t % 10 == 3) begin
                llx = maxs - step * $urandom_range(0, 1);
                send(llx, lly, maxs, lly + ny * step, ss);
            end else begin
                send(llx, lly, llx + nx * step, lly + ny * step, ss);
            end
        end
        ready_mode = 0;
        wait_drain("drain_random");

`ifdef RAST_SAMPLE_ITER_STATS_EN
        chk("stat_tri", stat_tri_o, m_tri);
        chk("stat_samp", stat_samp_o, m_samp);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rast_sample_iter.md
Name: rast_sample_iter

Overview:
- Parametrised successor to the single-sample rasterizer iterator stage. It accepts one triangle plus its snapped bounding box per handshake.
- It walks the box in raster order at a run-time-selectable subsample step, emitting LANES horizontally adjacent sample positions per beat with a per-lane valid mask.
- Sits between the bbox stage and the hash/sample-test stages. Upstream and downstream use valid/ready handshakes.

Parameters:
- SIGFIG, 24, bits per coordinate/color component (signed fixed point)
- RADIX, 10, fraction bits
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex (x,y,z)
- COLORS, 3, color channels
- LANES, 2, samples emitted per beat along x (power of two, 1..8)
- SS_MAX, 3, maximum log2 subsamples per pixel axis (ss_shift range 0..SS_MAX)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  triangle/box available
- in_ready  out  1  block can capture
- tri_i  in  VERTS*AXIS*SIGFIG  vertex positions
- color_i  in  COLORS*SIGFIG  triangle color
- box_ll_i  in  2*SIGFIG  lower-left {y,x}, snapped to step grid
- box_ur_i  in  2*SIGFIG  upper-right {y,x}, snapped to step grid
- ss_shift_i  in  $clog2(SS_MAX+1)  log2 subsamples per axis; step = 1<<(RADIX-ss_shift)
- out_valid  out  1  beat valid
- out_ready  in  1  downstream accepts
- tri_o, color_o  out  as inputs  captured triangle, held for all beats
- samp_y_o  out  SIGFIG  row y
- samp_x_o  out  LANES*SIGFIG  lane k x = cur_x + k*step
- lane_mask_o  out  LANES  lane k valid iff x_k <= ur.x
- last_o  out  1  final beat of triangle

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; out_valid=0, last_o=0, lane_mask_o=0, all data registers 0. in_ready=0 while rst==0.
- States IDLE, ITER.
- IDLE: in_ready=1.
  - in_valid&in_ready with ll.x<=ur.x and ll.y<=ur.y (signed compare): capture tri, color, box and step; cur=(ll.x,ll.y); go ITER. out_valid rises next cycle (latency 1).
  - Degenerate box (ll>ur on either axis): consumed and dropped; stay IDLE; nothing emitted.
- ITER: out_valid=1. Outputs are combinational from registered cur/box and are stable while out_ready=0.
- Beat advances only on out_valid&out_ready:
  - If cur_x+LANES*step > ur.x and cur_y+step > ur.y: last beat; last_o=1; go IDLE.
  - Else if cur_x+LANES*step > ur.x: cur_x=ll.x, cur_y+=step.
  - Else cur_x+=LANES*step.
- Back-to-back: in_ready = IDLE | (ITER & last_o & out_ready). A triangle captured on the last beat starts ITER next cycle with no bubble; the degenerate-drop rule still applies.
- Arithmetic: all adds/compares use SIGFIG+1 bit signed math so that ur near max positive cannot wrap. Lane x outputs are truncated to SIGFIG; masked lanes may carry wrapped values and must be ignored downstream.
- ss_shift_i is sampled only at capture. Values > SS_MAX are clamped to SS_MAX.
- Lane 0 is always valid on every emitted beat.

Optional Feature:
- RAST_SAMPLE_ITER_STATS_EN defined:
  - Adds outputs stat_tri_o (32) and stat_samp_o (32).
  - stat_tri_o counts non-degenerate captures.
  - stat_samp_o adds popcount(lane_mask_o) on each accepted beat.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Extend rast_params with LANES and SS_MAX.
- Add typedefs to rast_params: vert_t (AXIS x SIGFIG signed), tri_t (VERTS x vert_t), color_t, point2_t {y,x}, iter_state_e {IDLE, ITER}.
- One sub-module, rast_lane_gen (combinational): given cur_x, step, ur.x, it produces LANES x positions, lane_mask and the row-end flag.

Test Plan:
- RADIX=10, LANES=2, ss_shift=0, ll=(0,0), ur=(2048,1024), out_ready=1 -> 4 beats in this order:
  - (y0,x0/1024, mask 11)
  - (y0,x2048, mask 01)
  - (y1024,x0, mask 11)
  - (y1024,x2048, mask 01, last=1)
  - then IDLE.
- ss_shift=2 (step 256), ll=(0,0), ur=(256,256) -> 2 beats, x=0/256, mask 11 on each, y=0 then 256; last on beat 2.
- Same box, out_ready low 3 cycles mid-row -> outputs unchanged for 3 cycles, no beat skipped or repeated.
- ll.x=4096, ur.x=0 -> out_valid stays 0, in_ready stays 1, stat_tri_o unchanged.
- Second triangle presented during the last beat of the first with out_ready=1 -> captured that cycle; its first beat appears the next cycle with no bubble.
- rst low during ITER -> next cycle out_valid=0, in_ready=0; after release, in_ready=1 and no residual beats.
